// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings and default width.
package serial_adder_pkg;
  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the only arithmetic slice of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: LSB-first through one full adder, result published
// atomically WIDTH cycles after the accepting edge.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa, r_sb, r_r;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_s, w_co;

  full_adder u_fa (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_r     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_r   <= {w_s, r_r[WIDTH-1:1]};
          r_c   <= w_co;
          r_cnt <= r_cnt + 1'b1;
          // Last bit: publish directly from the cell so sum/cout move in one edge.
          if (r_cnt == LAST) begin
            sum     <= {w_s, r_r[WIDTH-1:1]};
            cout    <= w_co;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench: stimulus pushes (a+b) results, a negedge monitor pops on done.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int vectors = 0;
  int errors  = 0;
  logic [W:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain unsigned addition, carry-out is bit W of the full sum.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("sum", 64'(sum), 64'(e[W-1:0]));
        chk("cout", 64'(cout), 64'(e[W]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive operands with start for one edge; returns right after the accepting edge.
  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    a = x; b = y; start = 1'b1;
    if (push) exp_q.push_back(ref_add(x, y));
    tick;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
  endtask

  // n0 = edges already elapsed since the accepting edge; done must land at edge 8.
  task automatic wait_done(input int n0);
    int n = n0;
    while (!done && n < 20) begin
      chk("busy_run", 64'(busy), 64'd1);
      tick;
      n++;
    end
    chk("latency", 64'(n), 64'(W));
    chk("busy_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] x, y;
    repeat (2) tick;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum",  64'(sum),  64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    tick;

    accept(8'h00, 8'h00, 1); wait_done(0); tick;

    accept(8'hFF, 8'h01, 1); wait_done(0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_sum", 64'(sum), 64'h00);
      chk("hold_done", 64'(done), 64'd0);
    end

    accept(8'hA5, 8'h5A, 1); wait_done(0); tick;
    accept(8'h80, 8'h80, 1); wait_done(0); tick;

    // start during RUN must be ignored
    accept(8'h12, 8'h34, 1);
    tick; tick;
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(3);
    repeat (12) tick;
    chk("ignored_start_queue", 64'(exp_q.size()), 64'd0);

    // reset mid-RUN aborts with no done pulse
    accept(8'h0F, 8'h01, 0);
    repeat (3) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum",  64'(sum),  64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    repeat (15) tick;

    // back-to-back with start held through done
    a = 8'h7F; b = 8'h01; start = 1'b1;
    exp_q.push_back(ref_add(8'h7F, 8'h01));
    tick;
    a = 8'hC8; b = 8'h64;
    wait_done(0);
    exp_q.push_back(ref_add(8'hC8, 8'h64));
    tick;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(0);
    tick;

    for (int i = 0; i < 24; i++) begin
      x = W'($urandom); y = W'($urandom);
      accept(x, y, 1);
      wait_done(0);
      repeat ($urandom_range(0, 2)) tick;
    end
    tick; tick;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
